// File: rtl/image_read_ctrl.sv
// ============================================================================
// Module   : image_read_ctrl
// Brief    : Reads an interleaved RGB frame buffer one byte per cycle and
//            presents pixels in top-down raster order over a valid/ready port.
//            Define IMG_BOTTOM_UP_EN when the buffer stores rows bottom-first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module image_read_ctrl #(
    parameter int WIDTH  = 768,
    parameter int HEIGHT = 512,
    parameter int AW     = 21
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rdata,
    output logic          px_valid,
    input  logic          px_ready,
    output logic [7:0]    px_r,
    output logic [7:0]    px_g,
    output logic [7:0]    px_b,
    output logic [15:0]   px_row,
    output logic [15:0]   px_col
);

    localparam int          ROW_BYTES = 3 * WIDTH;
    localparam logic [15:0] LAST_COL  = 16'(WIDTH - 1);
    localparam logic [15:0] LAST_ROW  = 16'(HEIGHT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_R  = 3'd1,
        RD_G  = 3'd2,
        RD_B  = 3'd3,
        CAP_B = 3'd4,
        OUT   = 3'd5,
        FIN   = 3'd6
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [15:0]   row;
    logic [15:0]   col;
    logic [15:0]   src_row;
    logic [AW-1:0] base;
    logic [AW-1:0] rd_addr;
    logic          accept;
    logic          last_px;

`ifdef IMG_BOTTOM_UP_EN
    assign src_row = LAST_ROW - row;
`else
    assign src_row = row;
`endif

    assign base    = AW'(ROW_BYTES) * AW'(src_row) + AW'(3) * AW'(col);
    assign accept  = (state == OUT) && px_ready;
    assign last_px = (row == LAST_ROW) && (col == LAST_COL);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        mem_rd_en = 1'b0;
        rd_addr   = base;
        px_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = RD_R;
            end
            RD_R: begin
                mem_rd_en = 1'b1;
                state_nxt = RD_G;
            end
            RD_G: begin
                mem_rd_en = 1'b1;
                rd_addr   = base + AW'(1);
                state_nxt = RD_B;
            end
            RD_B: begin
                mem_rd_en = 1'b1;
                rd_addr   = base + AW'(2);
                state_nxt = CAP_B;
            end
            CAP_B: state_nxt = OUT;
            OUT: begin
                px_valid = 1'b1;
                if (px_ready) state_nxt = last_px ? FIN : RD_R;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address is forced to zero whenever no read is in flight.
    assign mem_addr = mem_rd_en ? rd_addr : '0;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            row  <= '0;
            col  <= '0;
            px_r <= '0;
            px_g <= '0;
            px_b <= '0;
        end else begin
            if (state == IDLE && start) begin
                row <= '0;
                col <= '0;
            end
            // Each byte arrives one cycle after its strobe.
            if (state == RD_G)  px_r <= mem_rdata;
            if (state == RD_B)  px_g <= mem_rdata;
            if (state == CAP_B) px_b <= mem_rdata;
            if (accept && !last_px) begin
                if (col == LAST_COL) begin
                    col <= '0;
                    row <= row + 16'd1;
                end else begin
                    col <= col + 16'd1;
                end
            end
        end
    end

    assign px_row = row;
    assign px_col = col;

endmodule

`default_nettype wire
